// File: rtl/cfu_ram_slave.sv
// cfu_ram_slave: Wishbone-classic responder for the CFU cfu_ram_* master port.
// Backs the bus with a local word-addressed scratchpad that the host preloads
// through a valid/ready load port. A fixed number of wait states is inserted
// before every ack/err. Bus-side writes exist only when CFU_RAM_SLAVE_WRITE_EN
// is defined; otherwise every write request completes with err.
module cfu_ram_slave #(
  parameter int          DEPTH       = 256,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [29:0]              cfu_ram_adr,
  input  logic [31:0]              cfu_ram_dat_mosi,
  input  logic [3:0]               cfu_ram_sel,
  input  logic                     cfu_ram_cyc,
  input  logic                     cfu_ram_stb,
  input  logic                     cfu_ram_we,
  input  logic [2:0]               cfu_ram_cti,
  input  logic [1:0]               cfu_ram_bte,
  output logic [31:0]              cfu_ram_dat_miso,
  output logic                     cfu_ram_ack,
  output logic                     cfu_ram_err,
  input  logic                     load_valid,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     load_ready
);
  localparam int AW = $clog2(DEPTH);
`ifdef CFU_RAM_SLAVE_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic        rdy_q;
  logic [31:0] mem [DEPTH];

  logic        req;
  logic [30:0] off;
  logic        hit;
  logic [AW-1:0] idx;

  assign req = cfu_ram_cyc & cfu_ram_stb;

  // 31-bit offset: an address below BASE_ADDR wraps to a huge value and
  // misses, and BASE_ADDR+DEPTH cannot overflow past 30'h3FFF_FFFF.
  assign off = {1'b0, adr_q} - {1'b0, BASE_ADDR};
  assign hit = off < 31'(DEPTH);
  assign idx = AW'(off);

  // The host may load only while the bus is idle; the bus wins a conflict.
  assign load_ready = rdy_q & (state_q == S_IDLE) & ~req;

  // Next-state logic: accept in IDLE, count wait states, respond for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    unique case (state_q)
      S_IDLE: if (req) begin
        adr_d   = cfu_ram_adr;
        we_d    = cfu_ram_we;
        cnt_d   = 4'(WAIT_STATES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!cfu_ram_cyc)      state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_RESP;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response outputs are decoded from the RESP state only, so they are 0 in reset.
  always_comb begin
    cfu_ram_ack      = 1'b0;
    cfu_ram_err      = 1'b0;
    cfu_ram_dat_miso = 32'h0;
    if (state_q == S_RESP) begin
      if (!hit || (we_q && !WR_EN)) begin
        cfu_ram_err = 1'b1;
      end else begin
        cfu_ram_ack = 1'b1;
        if (!we_q) cfu_ram_dat_miso = mem[idx];
      end
    end
  end

  // Control registers; an asynchronous reset drops any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 30'h0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      rdy_q   <= 1'b1;
    end
  end

`ifdef CFU_RAM_SLAVE_WRITE_EN
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic        unused_inputs;
  assign unused_inputs = ^{cfu_ram_cti, cfu_ram_bte};

  // Write data and byte lanes captured with the request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= 4'h0;
      dat_q <= 32'h0;
    end else if (state_q == S_IDLE && req) begin
      sel_q <= cfu_ram_sel;
      dat_q <= cfu_ram_dat_mosi;
    end
  end

  // Scratchpad: host preload, plus lane-masked bus writes at the RESP edge.
  always_ff @(posedge clk) begin
    if (load_valid && load_ready) mem[load_addr] <= load_data;
    if (state_q == S_RESP && we_q && hit) begin
      for (int i = 0; i < 4; i++)
        if (sel_q[i]) mem[idx][8*i +: 8] <= dat_q[8*i +: 8];
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{cfu_ram_cti, cfu_ram_bte, cfu_ram_sel, cfu_ram_dat_mosi};

  // Scratchpad: written only by the host preload port.
  always_ff @(posedge clk) begin
    if (load_valid && load_ready) mem[load_addr] <= load_data;
  end
`endif

endmodule
